// File: rtl/divmmc_pkg.sv
// Shared DivMMC definitions: port-decoder addresses, SPI shifter states and the
// default byte clocked out on read-ahead transfers.
package divmmc_pkg;

    localparam logic [7:0] DIVMMC_PORT_CTRL  = 8'hE3;
    localparam logic [7:0] DIVMMC_PORT_CS    = 8'hE7;
    localparam logic [7:0] DIVMMC_PORT_SPI   = 8'hEB;

    localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } spi_state_t;

endpackage

// File: rtl/divmmc_spi_clkdiv.sv
// SCK half-period tick generator. The tick falls in the last clk cycle of each
// half-period; restart lines the next half-period up with the following cycle.
module divmmc_spi_clkdiv #(
    parameter int HALF_PERIOD = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam logic [7:0] RELOAD = 8'(HALF_PERIOD - 1);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (reset || restart || count == 8'd0) begin
            count <= RELOAD;
        end else begin
            count <= count - 8'd1;
        end
    end

    assign tick = (count == 8'd0) && !restart;

endmodule

// File: rtl/divmmc_spi.sv
// Byte-wide SPI mode-0 master behind DivMMC port 0xEB, with a one-deep pending
// slot so that strobes arriving mid-transfer are queued instead of lost.
module divmmc_spi
    import divmmc_pkg::*;
#(
    parameter int         HALF_PERIOD = 2,
    parameter logic [7:0] IDLE_BYTE   = DEFAULT_IDLE_BYTE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_strobe,
    input  logic       rx_strobe,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       busy,
    output logic       done,
    output logic       spi_clk,
    input  logic       spi_di,
    output logic       spi_do
);

    spi_state_t state;
    logic [7:0] shift_reg;
    logic [7:0] rx_reg;
    logic [7:0] pend_byte;
    logic       pend_valid;
    logic [2:0] bit_cnt;
    logic       tick;
    logic       restart;
    logic       strobe;
    logic [7:0] strobe_byte;

    // A simultaneous tx and rx strobe is treated as a plain tx; the read-ahead is dropped.
    assign strobe      = tx_strobe || rx_strobe;
    assign strobe_byte = tx_strobe ? din : IDLE_BYTE;
    assign restart     = (state == ST_LOAD);

    divmmc_spi_clkdiv #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_clkdiv (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            shift_reg  <= 8'h00;
            rx_reg     <= 8'h00;
            pend_byte  <= 8'h00;
            pend_valid <= 1'b0;
            bit_cnt    <= 3'd0;
            dout       <= 8'hFF;
            busy       <= 1'b0;
            done       <= 1'b0;
            spi_clk    <= 1'b0;
            spi_do     <= 1'b1;
        end else begin
            done <= 1'b0;
            if (strobe && state != ST_IDLE) begin
                pend_valid <= 1'b1;
                pend_byte  <= strobe_byte;
            end
            case (state)
                ST_IDLE: begin
                    if (strobe) begin
                        state     <= ST_LOAD;
                        shift_reg <= strobe_byte;
                        bit_cnt   <= 3'd7;
                        busy      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    spi_do  <= shift_reg[7];
                    spi_clk <= 1'b0;
                    state   <= ST_LOW;
                end
                ST_LOW: begin
                    if (tick) begin
                        spi_clk <= 1'b1;
                        rx_reg  <= {rx_reg[6:0], spi_di};
                        state   <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tick) begin
                        spi_clk <= 1'b0;
                        if (bit_cnt != 3'd0) begin
                            bit_cnt   <= bit_cnt - 3'd1;
                            shift_reg <= {shift_reg[6:0], 1'b0};
                            spi_do    <= shift_reg[6];
                            state     <= ST_LOW;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    dout   <= rx_reg;
                    done   <= 1'b1;
                    spi_do <= 1'b1;
                    // A strobe in this very cycle overwrites the slot before it is consumed.
                    if (strobe) begin
                        state      <= ST_LOAD;
                        shift_reg  <= strobe_byte;
                        bit_cnt    <= 3'd7;
                        pend_valid <= 1'b0;
                    end else if (pend_valid) begin
                        state      <= ST_LOAD;
                        shift_reg  <= pend_byte;
                        bit_cnt    <= 3'd7;
                        pend_valid <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divmmc_spi.sv
// Directed plus randomized bench for divmmc_spi: an SD-card MISO model, a MOSI
// capture log and a small reference model of wire bytes, dout and timing.
module tb_divmmc_spi;

    localparam logic [7:0] TB_IDLE_BYTE = 8'hFF;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_strobe, rx_strobe;
    logic [7:0] din;
    logic [7:0] dout;
    logic       busy, done, spi_clk, spi_di, spi_do;

    logic       tx2, rx2;
    logic [7:0] din2, dout2;
    logic       busy2, done2, spi_clk2, spi_di2, spi_do2;

    int         n_checks = 0;
    int         n_fail   = 0;

    int         edge_cnt  = 0;
    int         edge_base = 0;
    int         done_cnt  = 0;
    int         edges2    = 0;
    int         miso_rel;
    logic       mosi_bits [0:4095];
    logic [7:0] miso_arr  [0:7];

    always #5 clk = ~clk;

    divmmc_spi #(.HALF_PERIOD(2), .IDLE_BYTE(8'hFF)) dut (
        .clk(clk), .reset(reset), .tx_strobe(tx_strobe), .rx_strobe(rx_strobe),
        .din(din), .dout(dout), .busy(busy), .done(done),
        .spi_clk(spi_clk), .spi_di(spi_di), .spi_do(spi_do)
    );

    divmmc_spi #(.HALF_PERIOD(1), .IDLE_BYTE(8'hFF)) dut_fast (
        .clk(clk), .reset(reset), .tx_strobe(tx2), .rx_strobe(rx2),
        .din(din2), .dout(dout2), .busy(busy2), .done(done2),
        .spi_clk(spi_clk2), .spi_di(spi_di2), .spi_do(spi_do2)
    );

    // The fast instance talks to itself, so a correct transfer echoes din.
    assign spi_di2 = spi_do2;

    always @(posedge spi_clk) begin
        if (edge_cnt < 4096) mosi_bits[edge_cnt] = spi_do;
        edge_cnt = edge_cnt + 1;
    end

    always @(posedge spi_clk2) edges2 = edges2 + 1;
    always @(posedge done) done_cnt = done_cnt + 1;

    // Card model: bit k of the transfer stream is presented until the k-th rising SCK.
    always_comb begin
        miso_rel = edge_cnt - edge_base;
        if (miso_rel >= 0 && miso_rel < 64) spi_di = miso_arr[miso_rel / 8][7 - (miso_rel % 8)];
        else spi_di = 1'b1;
    end

    function automatic logic [7:0] mosi_byte(input int k);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[7-j] = mosi_bits[edge_base + 8*k + j];
        return b;
    endfunction

    function automatic logic [7:0] model_wire_byte(input logic is_tx, input logic [7:0] d);
        return is_tx ? d : TB_IDLE_BYTE;
    endfunction

    function automatic int model_latency(input int hp);
        return 1 + 1 + 16*hp + 1;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic t, input logic r, input logic [7:0] d);
        tx_strobe = t;
        rx_strobe = r;
        din       = d;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 1) apply_stimulus(1'b0, 1'b0, 8'h00);
            lat = c;
            if (done) break;
        end
        check_output("done_seen", {31'd0, done}, 32'd1);
    endtask

    int         lat, dn, gaps, cyc, toggles, dc0, e0;
    logic       first_lvl, prev_lvl, hit, r_tx;
    logic [7:0] r_d, r_m;
    logic [7:0] pend_strobes [0:1];

    initial begin
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 8'h00);
        tx2 = 1'b0; rx2 = 1'b0; din2 = 8'h00;
        for (int i = 0; i < 8; i++) miso_arr[i] = 8'hFF;
        repeat (3) @(negedge clk);
        check_output("reset_dout",    {24'd0, dout}, 32'hFF);
        check_output("reset_busy",    {31'd0, busy}, 32'd0);
        check_output("reset_done",    {31'd0, done}, 32'd0);
        check_output("reset_spi_clk", {31'd0, spi_clk}, 32'd0);
        check_output("reset_spi_do",  {31'd0, spi_do}, 32'd1);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] reset abort at SCK edge 4");
        edge_base = edge_cnt;
        miso_arr[0] = 8'h55;
        dc0 = done_cnt;
        apply_stimulus(1'b1, 1'b0, 8'h96);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) apply_stimulus(1'b0, 1'b0, 8'h00);
            if (edge_cnt - edge_base >= 4) break;
        end
        check_output("abort_edges_reached", edge_cnt - edge_base, 32'd4);
        reset = 1'b1;
        @(negedge clk);
        check_output("abort_spi_clk", {31'd0, spi_clk}, 32'd0);
        check_output("abort_spi_do",  {31'd0, spi_do}, 32'd1);
        check_output("abort_busy",    {31'd0, busy}, 32'd0);
        check_output("abort_dout",    {24'd0, dout}, 32'hFF);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        check_output("abort_no_done", done_cnt - dc0, 32'd0);
        check_output("abort_no_more_edges", edge_cnt - edge_base, 32'd4);

        $display("[TB] tx A5 with card byte 3C");
        edge_base = edge_cnt;
        miso_arr[0] = 8'h3C;
        apply_stimulus(1'b1, 1'b0, 8'hA5);
        wait_done(lat);
        check_output("a5_latency", lat, model_latency(2));
        check_output("a5_dout",    {24'd0, dout}, 32'h3C);
        check_output("a5_busy",    {31'd0, busy}, 32'd0);
        check_output("a5_mosi",    {24'd0, mosi_byte(0)}, {24'd0, model_wire_byte(1'b1, 8'hA5)});
        check_output("a5_edges",   edge_cnt - edge_base, 32'd8);

        $display("[TB] read-ahead with card byte 81");
        @(negedge clk);
        edge_base = edge_cnt;
        miso_arr[0] = 8'h81;
        apply_stimulus(1'b0, 1'b1, 8'h00);
        check_output("rx_dout_strobe_cycle", {24'd0, dout}, 32'h3C);
        wait_done(lat);
        check_output("rx_latency", lat, model_latency(2));
        check_output("rx_mosi",    {24'd0, mosi_byte(0)}, {24'd0, model_wire_byte(1'b0, 8'h00)});
        check_output("rx_dout",    {24'd0, dout}, 32'h81);

        $display("[TB] pending slot, last writer wins");
        @(negedge clk);
        edge_base = edge_cnt;
        miso_arr[0] = 8'h12; miso_arr[1] = 8'h34;
        pend_strobes[0] = 8'h22; pend_strobes[1] = 8'h33;
        dc0 = done_cnt;
        dn = 0; gaps = 0;
        apply_stimulus(1'b1, 1'b0, 8'h11);
        for (cyc = 1; cyc <= 400 && dn < 2; cyc++) begin
            @(negedge clk);
            if (cyc == 6)       apply_stimulus(1'b1, 1'b0, pend_strobes[0]);
            else if (cyc == 12) apply_stimulus(1'b1, 1'b0, pend_strobes[1]);
            else                apply_stimulus(1'b0, 1'b0, 8'h00);
            if (done) dn++;
            if (dn < 2 && !busy) gaps++;
        end
        check_output("pend_done_pulses", dn, 32'd2);
        check_output("pend_busy_gaps",   gaps, 32'd0);
        check_output("pend_byte0",       {24'd0, mosi_byte(0)}, 32'h11);
        check_output("pend_byte1",       {24'd0, mosi_byte(1)}, {24'd0, pend_strobes[1]});
        check_output("pend_dout",        {24'd0, dout}, 32'h34);
        repeat (60) @(negedge clk);
        check_output("pend_total_edges", edge_cnt - edge_base, 32'd16);
        check_output("pend_total_done",  done_cnt - dc0, 32'd2);
        check_output("pend_busy_after",  {31'd0, busy}, 32'd0);

        $display("[TB] simultaneous tx and rx");
        edge_base = edge_cnt;
        miso_arr[0] = 8'hE1;
        dc0 = done_cnt;
        apply_stimulus(1'b1, 1'b1, 8'h5A);
        wait_done(lat);
        check_output("both_mosi", {24'd0, mosi_byte(0)}, 32'h5A);
        check_output("both_dout", {24'd0, dout}, 32'hE1);
        repeat (60) @(negedge clk);
        check_output("both_edges", edge_cnt - edge_base, 32'd8);
        check_output("both_done",  done_cnt - dc0, 32'd1);
        check_output("both_busy",  {31'd0, busy}, 32'd0);

        $display("[TB] HALF_PERIOD=1 loopback");
        e0 = edges2; toggles = 0; hit = 1'b0; lat = 0;
        first_lvl = 1'b1; prev_lvl = 1'b0;
        tx2 = 1'b1; din2 = 8'hC3;
        for (int c = 1; c <= 100 && !hit; c++) begin
            @(negedge clk);
            if (c == 1) tx2 = 1'b0;
            if (c >= 2 && c <= 17) begin
                if (c == 2) first_lvl = spi_clk2;
                else if (spi_clk2 !== prev_lvl) toggles++;
                prev_lvl = spi_clk2;
            end
            if (done2) begin hit = 1'b1; lat = c; end
        end
        check_output("fast_done_seen", {31'd0, hit}, 32'd1);
        check_output("fast_latency",   lat, model_latency(1));
        check_output("fast_first_lvl", {31'd0, first_lvl}, 32'd0);
        check_output("fast_toggles",   toggles, 32'd15);
        check_output("fast_edges",     edges2 - e0, 32'd8);
        check_output("fast_dout",      {24'd0, dout2}, 32'hC3);
        check_output("fast_busy",      {31'd0, busy2}, 32'd0);

        $display("[TB] randomized transfers");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            r_tx = 1'($urandom_range(0, 1));
            r_d  = 8'($urandom);
            r_m  = 8'($urandom);
            edge_base = edge_cnt;
            miso_arr[0] = r_m;
            apply_stimulus(r_tx, !r_tx, r_d);
            wait_done(lat);
            check_output("rand_latency", lat, model_latency(2));
            check_output("rand_mosi",    {24'd0, mosi_byte(0)}, {24'd0, model_wire_byte(r_tx, r_d)});
            check_output("rand_dout",    {24'd0, dout}, {24'd0, r_m});
            check_output("rand_busy",    {31'd0, busy}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
